// File: rtl/tile_pattern_mem.sv
// rtl/tile_pattern_mem.sv - tile/sprite pattern store with flipped pixel lookup and a clear engine
// Reads land two cycles after the request; writes and the clear engine share one RAM write port.
module tile_pattern_mem #(
  parameter int NUM_TILES = 64,
  parameter int SEL_W     = 6,
  parameter int DIM_LOG2  = 4,
  parameter int BPP       = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rd_valid,
  input  logic [SEL_W-1:0]    rd_select,
  input  logic [DIM_LOG2-1:0] rd_x,
  input  logic [DIM_LOG2-1:0] rd_y,
  input  logic                rd_hflip,
  input  logic                rd_vflip,
  output logic                out_valid,
  output logic [BPP-1:0]      out_pixel,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_select,
  input  logic [DIM_LOG2-1:0] wr_x,
  input  logic [DIM_LOG2-1:0] wr_y,
  input  logic [BPP-1:0]      wr_data,
  input  logic                clr_start,
  output logic                clr_busy
);

  localparam int ADDR_W = SEL_W + 2 * DIM_LOG2;
  localparam int DEPTH  = NUM_TILES << (2 * DIM_LOG2);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [SEL_W:0]    TILE_LIMIT = (SEL_W + 1)'(NUM_TILES);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state;
  state_t state_next;

  logic [BPP-1:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0]   clr_addr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [BPP-1:0]      mem_wdata;

  logic                rd_in_range;
  logic                wr_in_range;
  logic [DIM_LOG2-1:0] rd_xf;
  logic [DIM_LOG2-1:0] rd_yf;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;

  logic                s1_valid;
  logic                s1_zero;
  logic [ADDR_W-1:0]   s1_addr;

  // DIM-1-x is the bitwise complement because DIM is a power of two.
  assign rd_xf       = rd_hflip ? ~rd_x : rd_x;
  assign rd_yf       = rd_vflip ? ~rd_y : rd_y;
  assign rd_addr     = {rd_select, rd_xf, rd_yf};
  assign wr_addr     = {wr_select, wr_x, wr_y};
  assign rd_in_range = {1'b0, rd_select} < TILE_LIMIT;
  assign wr_in_range = {1'b0, wr_select} < TILE_LIMIT;
  assign clr_busy    = (state == CLEAR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    case (state)
      IDLE: begin
        // A write in the same cycle as clr_start still lands; the clear then overwrites it.
        mem_we = wr_en && wr_in_range;
        if (clr_start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
        if (clr_addr == LAST_ADDR) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + ADDR_W'(1);
    end else begin
      clr_addr <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Out-of-range or mid-clear requests still flow down the pipe but never touch the RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= rd_valid;
      s1_zero  <= !rd_in_range || (state == CLEAR);
      s1_addr  <= rd_in_range ? rd_addr : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixel <= s1_zero ? '0 : mem[s1_addr];
      end
    end
  end

endmodule

// File: tb/tb_tile_pattern_mem.sv
// tb/tb_tile_pattern_mem.sv - self-checking bench for tile_pattern_mem
// Word-level store model with a two-cycle result delay, plus directed checks on a 40-tile instance.
module tb_tile_pattern_mem;

  localparam int NT    = 64;
  localparam int WORDS = NT * 256;

  logic       clock;
  logic       reset_n;
  logic       rd_valid, rd_hflip, rd_vflip, wr_en, clr_start;
  logic [5:0] rd_select, wr_select;
  logic [3:0] rd_x, rd_y, wr_x, wr_y;
  logic [1:0] wr_data;
  logic       out_valid, clr_busy;
  logic [1:0] out_pixel;

  logic       r4_valid, w4_en;
  logic [5:0] r4_select, w4_select;
  logic [3:0] r4_x, r4_y, w4_x, w4_y;
  logic [1:0] w4_data;
  logic       out4_valid, busy4;
  logic [1:0] out4_pixel;

  int checks   = 0;
  int failures = 0;

  logic [1:0] model [0:WORDS-1];
  logic       clearing;
  int         clr_idx;
  logic       pend_valid, pend_zero;
  int         pend_addr;
  logic       exp_valid;
  logic [1:0] exp_pix;

  tile_pattern_mem dut (
    .clock(clock), .reset_n(reset_n),
    .rd_valid(rd_valid), .rd_select(rd_select), .rd_x(rd_x), .rd_y(rd_y),
    .rd_hflip(rd_hflip), .rd_vflip(rd_vflip),
    .out_valid(out_valid), .out_pixel(out_pixel),
    .wr_en(wr_en), .wr_select(wr_select), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_start(clr_start), .clr_busy(clr_busy)
  );

  tile_pattern_mem #(.NUM_TILES(40)) dut40 (
    .clock(clock), .reset_n(reset_n),
    .rd_valid(r4_valid), .rd_select(r4_select), .rd_x(r4_x), .rd_y(r4_y),
    .rd_hflip(1'b0), .rd_vflip(1'b0),
    .out_valid(out4_valid), .out_pixel(out4_pixel),
    .wr_en(w4_en), .wr_select(w4_select), .wr_x(w4_x), .wr_y(w4_y), .wr_data(w4_data),
    .clr_start(1'b0), .clr_busy(busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int word_addr(input int sel, input int x, input int y);
    return sel * 256 + x * 16 + y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: the model resolves the request sampled last edge against the store
  // before this edge's write, then takes this edge's request and write/clear.
  task automatic step();
    int xx, yy;
    @(posedge clock);
    if (!reset_n) begin
      pend_valid = 1'b0;
      exp_valid  = 1'b0;
      exp_pix    = 2'b00;
      clearing   = 1'b0;
    end else begin
      if (pend_valid) begin
        exp_valid = 1'b1;
        exp_pix   = pend_zero ? 2'b00 : model[pend_addr];
      end else begin
        exp_valid = 1'b0;
      end
      xx = rd_hflip ? 15 - int'(rd_x) : int'(rd_x);
      yy = rd_vflip ? 15 - int'(rd_y) : int'(rd_y);
      pend_valid = rd_valid;
      pend_zero  = clearing || (int'(rd_select) >= NT);
      pend_addr  = pend_zero ? 0 : word_addr(int'(rd_select), xx, yy);
      if (clearing) begin
        model[clr_idx] = 2'b00;
        if (clr_idx == WORDS - 1) clearing = 1'b0;
        else clr_idx++;
      end else begin
        if (wr_en && int'(wr_select) < NT)
          model[word_addr(int'(wr_select), int'(wr_x), int'(wr_y))] = wr_data;
        if (clr_start) begin
          clearing = 1'b1;
          clr_idx  = 0;
        end
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_pixel", 32'(out_pixel), 32'(exp_pix));
    check("clr_busy", 32'(clr_busy), 32'(clearing));
  endtask

  task automatic rand_read();
    rd_valid  = 1'($urandom_range(0, 1));
    rd_select = 6'($urandom_range(0, 3));
    rd_x      = 4'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(12, 15));
    rd_y      = 4'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(12, 15));
    rd_hflip  = 1'($urandom_range(0, 1));
    rd_vflip  = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_write(input logic [1:0] data);
    wr_en     = 1'($urandom_range(0, 1));
    wr_select = 6'($urandom_range(0, 3));
    wr_x      = 4'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(12, 15));
    wr_y      = 4'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(12, 15));
    wr_data   = data;
  endtask

  task automatic read_word(input int a);
    rd_valid  = 1'b1;
    rd_select = 6'(a / 256);
    rd_x      = 4'((a / 16) % 16);
    rd_y      = 4'(a % 16);
    rd_hflip  = 1'b0;
    rd_vflip  = 1'b0;
  endtask

  initial begin
    int cnt;
    int guard;
    int vcount;
    reset_n = 1'b1;
    rd_valid = 1'b0; rd_hflip = 1'b0; rd_vflip = 1'b0; wr_en = 1'b0; clr_start = 1'b0;
    rd_select = '0; wr_select = '0; rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_data = '0;
    r4_valid = 1'b0; w4_en = 1'b0; r4_select = '0; w4_select = '0;
    r4_x = '0; r4_y = '0; w4_x = '0; w4_y = '0; w4_data = '0;
    clearing = 1'b0; clr_idx = 0; pend_valid = 1'b0; pend_zero = 1'b0; pend_addr = 0;
    exp_valid = 1'b0; exp_pix = 2'b00;

    // Asynchronous reset, checked before the first clock edge
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    step();
    step();
    reset_n = 1'b1;

    // Initial clear brings the whole store to a known zero state
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < WORDS; i++) step();
    check("init_clear_done", 32'(clr_busy), 32'd0);

    // Single write then read, latency 2
    wr_en = 1'b1; wr_select = 6'd3; wr_x = 4'd2; wr_y = 4'd5; wr_data = 2'b10;
    step();
    wr_en = 1'b0;
    rd_valid = 1'b1; rd_select = 6'd3; rd_x = 4'd2; rd_y = 4'd5;
    step();
    rd_valid = 1'b0;
    check("t2_n1_valid", 32'(out_valid), 32'd0);
    step();
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_pixel", 32'(out_pixel), 32'd2);
    step();
    check("t2_n3_valid", 32'(out_valid), 32'd0);
    check("t2_hold", 32'(out_pixel), 32'd2);

    // Flipped lookups reach the same pixel
    rd_valid = 1'b1; rd_x = 4'd13; rd_y = 4'd5; rd_hflip = 1'b1;
    step();
    rd_x = 4'd2; rd_y = 4'd10; rd_hflip = 1'b0; rd_vflip = 1'b1;
    step();
    rd_valid = 1'b0; rd_vflip = 1'b0;
    check("t3_hflip", 32'(out_pixel), 32'd2);
    step();
    check("t3_vflip", 32'(out_pixel), 32'd2);
    check("t3_vflip_valid", 32'(out_valid), 32'd1);

    // Sixteen back-to-back reads of one row
    for (int x = 0; x < 16; x++) begin
      wr_en = 1'b1; wr_select = 6'd3; wr_x = 4'(x); wr_y = 4'd7; wr_data = 2'(x % 4);
      step();
    end
    wr_en = 1'b0;
    vcount = 0;
    for (int i = 0; i < 18; i++) begin
      rd_valid = (i < 16); rd_select = 6'd3; rd_x = 4'(i); rd_y = 4'd7;
      step();
      if (out_valid === 1'b1) vcount++;
    end
    rd_valid = 1'b0;
    check("t3_burst_count", 32'(vcount), 32'd16);

    // Randomised reads and writes over a few tiles
    for (int i = 0; i < 2000; i++) begin
      rand_read();
      rand_write(2'($urandom_range(0, 3)));
      step();
    end
    rd_valid = 1'b0; wr_en = 1'b0; rd_hflip = 1'b0; rd_vflip = 1'b0;
    step();
    step();

    // 40-tile instance: range handling
    w4_en = 1'b1; w4_select = 6'd10; w4_x = 4'd4; w4_y = 4'd4; w4_data = 2'b01;
    step();
    w4_select = 6'd50; w4_data = 2'b10;
    step();
    w4_en = 1'b0;
    r4_valid = 1'b1; r4_select = 6'd10; r4_x = 4'd4; r4_y = 4'd4;
    step();
    r4_select = 6'd63;
    step();
    check("r40_in_valid", 32'(out4_valid), 32'd1);
    check("r40_in_pixel", 32'(out4_pixel), 32'd1);
    r4_select = 6'd50;
    step();
    check("r40_oor63_valid", 32'(out4_valid), 32'd1);
    check("r40_oor63_pixel", 32'(out4_pixel), 32'd0);
    r4_select = 6'd10;
    step();
    check("r40_oor50_pixel", 32'(out4_pixel), 32'd0);
    r4_valid = 1'b0;
    step();
    check("r40_after_oorwr", 32'(out4_pixel), 32'd1);
    step();
    check("r40_idle_valid", 32'(out4_valid), 32'd0);
    check("r40_busy", 32'(busy4), 32'd0);

    // Fill whole store with 2'b11 while reading random words
    for (int a = 0; a < WORDS; a++) begin
      wr_en = 1'b1; wr_select = 6'(a / 256); wr_x = 4'((a / 16) % 16); wr_y = 4'(a % 16);
      wr_data = 2'b11;
      read_word(int'($urandom_range(0, WORDS - 1)));
      step();
    end

    // clr_start together with a write; then writes during busy must be ignored
    clr_start = 1'b1; wr_en = 1'b1; wr_select = 6'd0; wr_x = 4'd0; wr_y = 4'd5; wr_data = 2'b01;
    rd_valid = 1'b0;
    step();
    clr_start = 1'b0;
    cnt = (clr_busy === 1'b1) ? 1 : 0;
    guard = 0;
    while (clr_busy === 1'b1 && guard < 20000) begin
      rand_read();
      rand_write(2'b11);
      step();
      if (clr_busy === 1'b1) cnt++;
      guard++;
    end
    wr_en = 1'b0; rd_valid = 1'b0; rd_hflip = 1'b0; rd_vflip = 1'b0;
    check("clear_busy_cycles", 32'(cnt), 32'(WORDS));
    for (int a = 0; a < WORDS; a++) begin
      read_word(a);
      step();
    end
    rd_valid = 1'b0;
    step();
    step();

    // Reset in the middle of a clear
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b1; wr_select = 6'd0; wr_x = 4'(a / 16); wr_y = 4'(a % 16); wr_data = 2'b11;
      step();
    end
    wr_en = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 100; i++) step();
    reset_n = 1'b0;
    clearing = 1'b0; pend_valid = 1'b0; exp_valid = 1'b0; exp_pix = 2'b00;
    #1;
    check("midclr_busy", 32'(clr_busy), 32'd0);
    check("midclr_valid", 32'(out_valid), 32'd0);
    step();
    reset_n = 1'b1;
    read_word(200);
    step();
    read_word(99);
    step();
    read_word(100);
    check("word200", 32'(out_pixel), 32'd3);
    step();
    rd_valid = 1'b0;
    check("word99", 32'(out_pixel), 32'd0);
    step();
    check("word100", 32'(out_pixel), 32'd3);
    for (int a = 0; a < 256; a++) begin
      read_word(a);
      step();
    end
    rd_valid = 1'b0;
    step();
    step();

    // Read and write of the same word in the RAM access cycle
    wr_en = 1'b1; wr_select = 6'd1; wr_x = 4'd0; wr_y = 4'd0; wr_data = 2'b01;
    step();
    wr_en = 1'b0;
    read_word(256);
    step();
    rd_valid = 1'b0;
    wr_en = 1'b1; wr_data = 2'b10;
    step();
    wr_en = 1'b0;
    check("rbw_old", 32'(out_pixel), 32'd1);
    read_word(256);
    step();
    rd_valid = 1'b0;
    step();
    check("rbw_new", 32'(out_pixel), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
